// File: rtl/eth_xgmii_pkg.sv
// Shared XGMII constants, deframer state encoding and the emitted-word record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_xgmii_pkg;

  localparam logic [7:0]  XGMII_START   = 8'hFB;
  localparam logic [7:0]  XGMII_TERM    = 8'hFD;
  localparam logic [7:0]  XGMII_ERR     = 8'hFE;
  localparam logic [7:0]  XGMII_IDLE    = 8'h07;
  // Start control character in lane 0 followed by seven preamble/SFD bytes.
  localparam logic [63:0] PREAMBLE_WORD = 64'hD555_5555_5555_55FB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA    = 2'd1,
    ST_DISCARD = 2'd2
  } deframer_state_t;

  // One payload word as held internally and as presented on the output.
  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  bv;
    logic        sof;
    logic        eof;
    logic        err;
  } out_word_t;

  // Mask covering lanes 0..k-1 (zero for k == 0).
  function automatic logic [7:0] lane_mask(input logic [2:0] k);
    return (8'd1 << k) - 8'd1;
  endfunction

endpackage

// File: rtl/xgmii_rx_deframer_if.sv
// Clock/reset bundle and the 64-bit XGMII data/control bus seen by the deframer.
// Latency: n/a (wiring only).
// Backpressure: none; the XGMII bus delivers one word every cycle.
interface AXI_clks;
  logic clk;
  logic reset_n;
  modport to_rtl (input clk, input reset_n);
endinterface

interface tx_xgmii;
  logic [63:0] data;
  logic [7:0]  ctrl;
  modport to_rtl (input data, input ctrl);
endinterface

// File: rtl/xgmii_term_decode.sv
// Finds the lowest-lane terminate character in one XGMII word and checks its tail.
// Latency: combinational.
// Backpressure: none.
// Ports: data/ctrl in; term_found, term_lane (lowest lane holding a control 0xFD),
//        term_bad (some lane above term_lane is not a control-coded idle).
module xgmii_term_decode
  import eth_xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [7:0]  ctrl,
  output logic        term_found,
  output logic [2:0]  term_lane,
  output logic        term_bad
);

  always_comb begin
    term_found = 1'b0;
    term_lane  = 3'd0;
    // Scan downwards so the lowest matching lane wins.
    for (int i = 7; i >= 0; i--) begin
      if (ctrl[i] && (data[8*i +: 8] == XGMII_TERM)) begin
        term_found = 1'b1;
        term_lane  = 3'(i);
      end
    end

    term_bad = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (term_found && (3'(i) > term_lane) &&
          (!ctrl[i] || (data[8*i +: 8] != XGMII_IDLE))) begin
        term_bad = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_deframer.sv
// Strips start/terminate framing from an XGMII stream into lane-0-first payload words.
// Latency: 2 cycles input word to out_valid (one-word hold + output register).
// Backpressure: none; one word consumed per cycle, output cannot stall.
// Ports: clks (clk, async active-low reset_n), xgmii_rx (data/ctrl);
//        out_valid/out_data/out_bvalid/out_sof/out_eof/out_err payload stream;
//        frm_cnt good frames, err_cnt errored/discarded frames (both saturating).
module xgmii_rx_deframer
  import eth_xgmii_pkg::*;
#(
  parameter int MAX_WORDS = 190,
  parameter int MIN_WORDS = 8
) (
  AXI_clks.to_rtl      clks,
  tx_xgmii.to_rtl      xgmii_rx,
  output logic         out_valid,
  output logic [63:0]  out_data,
  output logic [7:0]   out_bvalid,
  output logic         out_sof,
  output logic         out_eof,
  output logic         out_err,
  output logic [31:0]  frm_cnt,
  output logic [15:0]  err_cnt
);

  localparam int            CW    = $clog2(MAX_WORDS + 2);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WORDS);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_WORDS);

  logic [63:0]     rx_dat;
  logic [7:0]      rx_ctl;
  logic            term_found;
  logic [2:0]      term_lane;
  logic            term_bad;
  logic            is_start;
  logic            bad_start;
  logic            term_ok;
  logic            room;
  logic [7:0]      part_bv;
  logic [63:0]     part_dat;

  deframer_state_t state;
  logic [CW-1:0]   wcnt;
  out_word_t       hold;
  logic            hold_vld;
  out_word_t       out_q;
  logic            out_vld;
  logic            err_evt;   // error counted without an emitted eof word

  logic            frm_inc;
  logic [1:0]      err_add;
  logic [16:0]     err_sum;

  assign rx_dat = xgmii_rx.data;
  assign rx_ctl = xgmii_rx.ctrl;

  xgmii_term_decode u_term_decode (
    .data       (rx_dat),
    .ctrl       (rx_ctl),
    .term_found (term_found),
    .term_lane  (term_lane),
    .term_bad   (term_bad)
  );

  always_comb begin
    is_start  = (rx_ctl == 8'h01) && (rx_dat == PREAMBLE_WORD);
    bad_start = !is_start &&
                ((rx_ctl[4] && (rx_dat[39:32] == XGMII_START)) ||
                 (rx_ctl[0] && (rx_dat[7:0]   == XGMII_START)));
    part_bv   = lane_mask(term_lane);
    // A terminate only counts if every lane before it is plain data.
    term_ok   = term_found && ((rx_ctl & part_bv) == 8'h00);
    room      = (wcnt != MAX_C);
    part_dat  = '0;
    for (int i = 0; i < 8; i++) begin
      part_dat[8*i +: 8] = part_bv[i] ? rx_dat[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clks.clk or negedge clks.reset_n) begin
    if (!clks.reset_n) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      out_q    <= '0;
      out_vld  <= 1'b0;
      err_evt  <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      out_q   <= '0;
      err_evt <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A pending partial eof word always drains here, whatever arrives.
          out_vld  <= hold_vld;
          out_q    <= hold;
          hold_vld <= 1'b0;
          hold     <= '0;
          if (is_start) begin
            state <= ST_DATA;
            wcnt  <= '0;
          end else if (bad_start) begin
            state   <= ST_DISCARD;
            err_evt <= 1'b1;
          end
        end

        ST_DATA: begin
          if (term_ok && (term_lane == 3'd0)) begin
            out_vld   <= hold_vld;
            out_q     <= hold;
            out_q.eof <= hold_vld;
            out_q.err <= hold_vld && (term_bad || (wcnt < MIN_C));
            err_evt   <= !hold_vld;       // zero-payload frame
            hold_vld  <= 1'b0;
            hold      <= '0;
            state     <= ST_IDLE;
          end else if (room && (rx_ctl == 8'h00)) begin
            out_vld  <= hold_vld;
            out_q    <= hold;
            hold_vld <= 1'b1;
            hold     <= '{dat: rx_dat, bv: 8'hFF, sof: (wcnt == '0), eof: 1'b0, err: 1'b0};
            wcnt     <= wcnt + CW'(1);
          end else if (room && term_ok) begin
            // Partial last word waits in hold and drains from IDLE next cycle.
            out_vld  <= hold_vld;
            out_q    <= hold;
            hold_vld <= 1'b1;
            hold     <= '{dat: part_dat, bv: part_bv, sof: (wcnt == '0), eof: 1'b1,
                          err: term_bad || ((wcnt + CW'(1)) < MIN_C)};
            state    <= ST_IDLE;
          end else begin
            // Bad control character, or the word after MAX_WORDS: abort the frame.
            out_vld   <= hold_vld;
            out_q     <= hold;
            out_q.eof <= hold_vld;
            out_q.err <= hold_vld;
            err_evt   <= !hold_vld;
            hold_vld  <= 1'b0;
            hold      <= '0;
            state     <= ST_DISCARD;
          end
        end

        ST_DISCARD: begin
          if (term_found || (rx_ctl == 8'hFF)) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counters follow the registered output stream one cycle later.
  always_comb begin
    frm_inc = out_vld && out_q.eof && !out_q.err;
    err_add = {1'b0, (out_vld && out_q.eof && out_q.err)} + {1'b0, err_evt};
    err_sum = {1'b0, err_cnt} + {15'd0, err_add};
  end

  always_ff @(posedge clks.clk or negedge clks.reset_n) begin
    if (!clks.reset_n) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (frm_inc && (frm_cnt != '1)) begin
        frm_cnt <= frm_cnt + 32'd1;
      end
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign out_valid  = out_vld;
  assign out_data   = out_q.dat;
  assign out_bvalid = out_q.bv;
  assign out_sof    = out_q.sof;
  assign out_eof    = out_q.eof;
  assign out_err    = out_q.err;

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
module tb_xgmii_rx_deframer;
  import eth_xgmii_pkg::*;

  localparam logic [63:0] IDLE_W   = 64'h0707_0707_0707_0707;
  localparam logic [63:0] T0_W     = 64'h0707_0707_0707_07FD;
  localparam logic [63:0] T0BAD_W  = 64'h0707_0707_0707_00FD;
  localparam logic [63:0] T2_W     = 64'h0707_0707_07FD_BBAA;
  localparam logic [63:0] T3_W     = 64'h0707_0707_FD33_2211;
  localparam logic [63:0] T4_W     = 64'h0707_07FD_DDCC_BBAA;
  localparam logic [63:0] T5_W     = 64'h0707_FD55_4433_2211;
  localparam logic [63:0] FE_W     = 64'h1111_1111_11FE_1111;
  localparam logic [63:0] BADPRE_W = 64'hD555_5555_5555_5AFB;
  localparam logic [63:0] L4FB_W   = 64'h5555_55FB_0707_0707;
  localparam logic [63:0] START_W  = 64'hD555_5555_5555_55FB;

  AXI_clks clks_if ();
  tx_xgmii rx_if ();

  logic        out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_bvalid;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [31:0] frm_cnt;
  logic [15:0] err_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_frm = '0;
  logic [15:0] exp_err = '0;

  xgmii_rx_deframer #(.MAX_WORDS(190), .MIN_WORDS(8)) dut (
    .clks       (clks_if),
    .xgmii_rx   (rx_if),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_bvalid (out_bvalid),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_err    (out_err),
    .frm_cnt    (frm_cnt),
    .err_cnt    (err_cnt)
  );

  initial clks_if.clk = 1'b0;
  always #5 clks_if.clk = ~clks_if.clk;

  function automatic logic [63:0] dw(input int n);
    return 64'hC0DE_0000_0000_0000 + 64'(n);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one word (we sit at a falling edge) and return at the next falling edge.
  task automatic cyc(input logic [63:0] d, input logic [7:0] c);
    rx_if.data = d;
    rx_if.ctrl = c;
    @(negedge clks_if.clk);
  endtask

  task automatic exp_none(input string tag);
    chk(tag, 64'(out_valid), 64'd0);
  endtask

  task automatic exp_word(input string tag, input logic [63:0] d, input logic [7:0] bv,
                          input logic sof, input logic eof, input logic err);
    chk({tag, ".ctl"}, {53'd0, out_valid, out_sof, out_eof, out_bvalid},
                       {53'd0, 1'b1, sof, eof, bv});
    chk({tag, ".dat"}, out_data, d);
    if (eof) chk({tag, ".err"}, 64'(out_err), 64'(err));
  endtask

  // n full data words; each word appears on the output when the next one arrives.
  task automatic run_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(dw(base + i), 8'h00);
      if (i == 0) exp_none("first_word_held");
      else exp_word("payload", dw(base + i - 1), 8'hFF, (i == 1), 1'b0, 1'b0);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".frm_cnt"}, 64'(frm_cnt), 64'(exp_frm));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    clks_if.reset_n = 1'b0;
    rx_if.data = IDLE_W;
    rx_if.ctrl = 8'hFF;
    #2;
    chk("reset.valid", 64'(out_valid), 64'd0);
    chk_cnt("reset");
    @(negedge clks_if.clk);
    @(negedge clks_if.clk);
    clks_if.reset_n = 1'b1;

    // 64-byte frame, lane-0 terminate on an idle word
    cyc(IDLE_W, 8'hFF);  exp_none("idle_ignored");
    cyc(START_W, 8'h01); exp_none("start_silent");
    run_words(1, 8);
    cyc(T0_W, 8'hFF);    exp_word("t0_last", dw(8), 8'hFF, 1'b0, 1'b1, 1'b0);
    cyc(IDLE_W, 8'hFF);  exp_none("t0_after");
    exp_frm++;           chk_cnt("frame64");

    // terminate in lane 3 after 8 full words
    cyc(START_W, 8'h01); exp_none("t3_start");
    run_words(11, 8);
    cyc(T3_W, 8'hF8);    exp_word("t3_word8", dw(18), 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(IDLE_W, 8'hFF);  exp_word("t3_partial", 64'h0000_0000_0033_2211, 8'h07, 1'b0, 1'b1, 1'b0);
    cyc(IDLE_W, 8'hFF);  exp_none("t3_after");
    exp_frm++;           chk_cnt("term_lane3");

    // 0xFE in lane 2 of word 4 aborts the frame, rest discarded
    cyc(START_W, 8'h01); exp_none("fe_start");
    run_words(21, 3);
    cyc(FE_W, 8'h04);    exp_word("fe_abort", dw(23), 8'hFF, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(dw(25 + i), 8'h00); exp_none("fe_discard");
    end
    cyc(T0_W, 8'hFF);    exp_none("fe_discard_term");
    cyc(IDLE_W, 8'hFF);  exp_none("fe_idle");
    exp_err++;           chk_cnt("fe_error");

    // oversize: 200 words against MAX_WORDS=190
    cyc(START_W, 8'h01); exp_none("big_start");
    for (int i = 1; i <= 200; i++) begin
      cyc(dw(100 + i), 8'h00);
      if (i == 1) exp_none("big_first");
      else if (i <= 190) exp_word("big_payload", dw(99 + i), 8'hFF, (i == 2), 1'b0, 1'b0);
      else if (i == 191) exp_word("big_eof", dw(290), 8'hFF, 1'b0, 1'b1, 1'b1);
      else exp_none("big_dropped");
    end
    cyc(IDLE_W, 8'hFF);  exp_none("big_idle");
    exp_err++;           chk_cnt("oversize");

    // back-to-back: lane-5 terminate then start on the very next cycle
    cyc(START_W, 8'h01); exp_none("b2b_start1");
    run_words(41, 8);
    cyc(T5_W, 8'hE0);    exp_word("b2b_word8", dw(48), 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(START_W, 8'h01); exp_word("b2b_partial", 64'h0000_0055_4433_2211, 8'h1F, 1'b0, 1'b1, 1'b0);
    run_words(51, 8);
    cyc(T0_W, 8'hFF);    exp_word("b2b_last", dw(58), 8'hFF, 1'b0, 1'b1, 1'b0);
    cyc(IDLE_W, 8'hFF);  exp_none("b2b_after");
    exp_frm += 2;        chk_cnt("back_to_back");

    // start immediately followed by lane-0 terminate
    cyc(START_W, 8'h01); exp_none("zero_start");
    cyc(T0_W, 8'hFF);    exp_none("zero_term");
    cyc(IDLE_W, 8'hFF);  exp_none("zero_after");
    exp_err++;           chk_cnt("zero_payload");

    // runt: 2 full words plus a 2-byte partial
    cyc(START_W, 8'h01); exp_none("runt_start");
    run_words(61, 2);
    cyc(T2_W, 8'hFC);    exp_word("runt_w2", dw(62), 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(IDLE_W, 8'hFF);  exp_word("runt_partial", 64'h0000_0000_0000_BBAA, 8'h03, 1'b0, 1'b1, 1'b1);
    cyc(IDLE_W, 8'hFF);  exp_none("runt_after");
    exp_err++;           chk_cnt("runt");

    // one-word frame: sof and eof together
    cyc(START_W, 8'h01); exp_none("one_start");
    cyc(T4_W, 8'hF0);    exp_none("one_term");
    cyc(IDLE_W, 8'hFF);  exp_word("one_word", 64'h0000_0000_DDCC_BBAA, 8'h0F, 1'b1, 1'b1, 1'b1);
    cyc(IDLE_W, 8'hFF);  exp_none("one_after");
    exp_err++;           chk_cnt("one_word");

    // terminate with a non-idle byte after it
    cyc(START_W, 8'h01); exp_none("bt_start");
    run_words(81, 8);
    cyc(T0BAD_W, 8'hFF); exp_word("bad_term", dw(88), 8'hFF, 1'b0, 1'b1, 1'b1);
    cyc(IDLE_W, 8'hFF);  exp_none("bt_after");
    exp_err++;           chk_cnt("bad_term");

    // bad preamble and lane-4 start both discard until idle/terminate
    cyc(BADPRE_W, 8'h01); exp_none("badpre");
    cyc(START_W, 8'h01);  exp_none("badpre_start_ignored");
    cyc(dw(1), 8'h00);    exp_none("badpre_data");
    cyc(IDLE_W, 8'hFF);   exp_none("badpre_idle");
    exp_err++;
    cyc(L4FB_W, 8'h1F);   exp_none("lane4_start");
    cyc(IDLE_W, 8'hFF);   exp_none("lane4_idle");
    exp_err++;            chk_cnt("bad_starts");

    // reset at word 4 of a frame
    cyc(START_W, 8'h01); exp_none("rst_start");
    run_words(71, 4);
    clks_if.reset_n = 1'b0;
    #1;
    chk("rst_async.valid", 64'(out_valid), 64'd0);
    chk("rst_async.data", out_data, 64'd0);
    exp_frm = '0;
    exp_err = '0;
    chk_cnt("rst_async");
    @(negedge clks_if.clk);
    clks_if.reset_n = 1'b1;
    cyc(dw(75), 8'h00);  exp_none("rst_drop1");
    cyc(dw(76), 8'h00);  exp_none("rst_drop2");
    cyc(T0_W, 8'hFF);    exp_none("rst_drop_term");
    cyc(IDLE_W, 8'hFF);  exp_none("rst_drop_idle");
    chk_cnt("rst_release");
    cyc(START_W, 8'h01); exp_none("clean_start");
    run_words(91, 8);
    cyc(T0_W, 8'hFF);    exp_word("clean_last", dw(98), 8'hFF, 1'b0, 1'b1, 1'b0);
    cyc(IDLE_W, 8'hFF);  exp_none("clean_after");
    exp_frm++;           chk_cnt("clean_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
